// File: rtl/game_frame_scheduler_if.sv
// Stage handshake and raster-scan bus between the frame scheduler and the game datapath.
// The scheduler drives the master side; the datapath answers on the slave side.
interface game_frame_scheduler_if;
    logic        physics_go;
    logic        physics_done;
    logic        collide_go;
    logic        collide_done;
    logic        view_go;
    logic        view_done;
    logic        render_valid;
    logic [31:0] render_x;
    logic [31:0] render_y;
    logic [31:0] render_index;

    modport master (
        output physics_go, collide_go, view_go,
        output render_valid, render_x, render_y, render_index,
        input  physics_done, collide_done, view_done
    );

    modport slave (
        input  physics_go, collide_go, view_go,
        input  render_valid, render_x, render_y, render_index,
        output physics_done, collide_done, view_done
    );
endinterface

// File: rtl/game_frame_scheduler.sv
// Per-frame sequencer: a frame tick divider plus an FSM that walks physics, collision,
// view and a raster scan, reporting frame completion, overruns and stage timeouts.
module game_frame_scheduler #(
    parameter int SCREEN_WIDTH  = 30,
    parameter int SCREEN_HEIGHT = 30,
    parameter int FRAME_PERIOD  = 2000,
    parameter int STAGE_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    game_frame_scheduler_if.master        bus,
    output logic                          frame_done,
    output logic [15:0]                   frame_count,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout
);

    localparam int DIV_W = $clog2(FRAME_PERIOD);
    localparam int CNT_W = (STAGE_TIMEOUT > 1) ? $clog2(STAGE_TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_TIMEOUT - 1);
    localparam logic [31:0]      X_LAST   = 32'(SCREEN_WIDTH - 1);
    localparam logic [31:0]      Y_LAST   = 32'(SCREEN_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, PHYS, COLL, VIEW, REND, DONE} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              physics_go_q, physics_go_d;
    logic              collide_go_q, collide_go_d;
    logic              view_go_q, view_go_d;
    logic              render_valid_q, render_valid_d;
    logic [31:0]       render_x_q, render_x_d;
    logic [31:0]       render_y_q, render_y_d;
    logic [31:0]       render_index_q, render_index_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              tick;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        tick           = enable && (div_q == DIV_LAST);
        div_d          = '0;
        if (enable) div_d = tick ? '0 : div_q + 1'b1;

        state_d        = state_q;
        cnt_d          = '0;
        physics_go_d   = 1'b0;
        collide_go_d   = 1'b0;
        view_go_d      = 1'b0;
        render_valid_d = 1'b0;
        render_x_d     = '0;
        render_y_d     = '0;
        render_index_d = '0;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count_q;
        timeout_d      = timeout_q;
        overrun_d      = tick && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d      = PHYS;
                    physics_go_d = 1'b1;
                end
            end
            PHYS: begin
                if (bus.physics_done || cnt_q == CNT_LAST) begin
                    state_d      = COLL;
                    collide_go_d = 1'b1;
                    if (!bus.physics_done) timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COLL: begin
                if (bus.collide_done || cnt_q == CNT_LAST) begin
                    state_d   = VIEW;
                    view_go_d = 1'b1;
                    if (!bus.collide_done) timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VIEW: begin
                // The first scan position (0,0) is presented in the first REND cycle.
                if (bus.view_done || cnt_q == CNT_LAST) begin
                    state_d        = REND;
                    render_valid_d = 1'b1;
                    if (!bus.view_done) timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REND: begin
                if (render_x_q == X_LAST && render_y_q == Y_LAST) begin
                    state_d       = DONE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    render_valid_d = 1'b1;
                    render_index_d = render_index_q + 32'd1;
                    if (render_y_q == Y_LAST) begin
                        render_x_d = render_x_q + 32'd1;
                    end else begin
                        render_x_d = render_x_q;
                        render_y_d = render_y_q + 32'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (reset) begin
            state_q        <= IDLE;
            div_q          <= '0;
            cnt_q          <= '0;
            physics_go_q   <= 1'b0;
            collide_go_q   <= 1'b0;
            view_go_q      <= 1'b0;
            render_valid_q <= 1'b0;
            render_x_q     <= '0;
            render_y_q     <= '0;
            render_index_q <= '0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            cnt_q          <= cnt_d;
            physics_go_q   <= physics_go_d;
            collide_go_q   <= collide_go_d;
            view_go_q      <= view_go_d;
            render_valid_q <= render_valid_d;
            render_x_q     <= render_x_d;
            render_y_q     <= render_y_d;
            render_index_q <= render_index_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.physics_go   = physics_go_q;
    assign bus.collide_go   = collide_go_q;
    assign bus.view_go      = view_go_q;
    assign bus.render_valid = render_valid_q;
    assign bus.render_x     = render_x_q;
    assign bus.render_y     = render_y_q;
    assign bus.render_index = render_index_q;
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_game_frame_scheduler.sv
// Directed bench: dut_a (period 40, timeout 8) covers sequencing, timeouts, reset and enable;
// dut_b (period 10) covers dropped ticks. Cycle k is the interval after the k-th edge since release.
module tb_game_frame_scheduler;
    localparam int W = 4;
    localparam int H = 3;
    localparam int SIG_PGO = 0;
    localparam int SIG_CGO = 1;
    localparam int SIG_VGO = 2;
    localparam int SIG_FD  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, rst_b, en_b;
    logic        a_fd, b_fd, a_busy, b_busy, a_ovr, b_ovr, a_to, b_to;
    logic [15:0] a_fc, b_fc;

    game_frame_scheduler_if a_if ();
    game_frame_scheduler_if b_if ();

    game_frame_scheduler #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAME_PERIOD(40), .STAGE_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .bus(a_if),
        .frame_done(a_fd), .frame_count(a_fc), .busy(a_busy),
        .overrun(a_ovr), .timeout(a_to)
    );

    game_frame_scheduler #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAME_PERIOD(10), .STAGE_TIMEOUT(8)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .bus(b_if),
        .frame_done(b_fd), .frame_count(b_fc), .busy(b_busy),
        .overrun(b_ovr), .timeout(b_to)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the chosen dut_a output is high; n = cycles advanced (limit on expiry).
    task automatic wait_a(input int sig, input int limit, output int n);
        logic hit;
        n = 0;
        do begin
            step();
            n++;
            case (sig)
                SIG_PGO: hit = a_if.physics_go;
                SIG_CGO: hit = a_if.collide_go;
                SIG_VGO: hit = a_if.view_go;
                default: hit = a_fd;
            endcase
        end while (!hit && n < limit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, fd_cnt, go_cnt, ovr_cnt, first_ovr;
        rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
        a_if.physics_done = 1'b1; a_if.collide_done = 1'b1; a_if.view_done = 1'b1;
        b_if.physics_done = 1'b1; b_if.collide_done = 1'b1; b_if.view_done = 1'b1;
        repeat (3) step();

        check("rst_busy", a_busy, 0);
        check("rst_frame_count", a_fc, 0);
        check("rst_valid", a_if.render_valid, 0);
        check("rst_timeout", a_to, 0);
        check("rst_physics_go", a_if.physics_go, 0);
        check("rst_b_busy", b_busy, 0);

        // Minimum-length frame: all stages answer in their go cycle.
        rst_a = 1'b0; en_a = 1'b1;
        wait_a(SIG_PGO, 200, n);
        check("s1_go_latency", n, 40);
        check("s1_busy", a_busy, 1);
        step();
        check("s1_collide_go", a_if.collide_go, 1);
        check("s1_physics_go_pulse", a_if.physics_go, 0);
        step();
        check("s1_view_go", a_if.view_go, 1);
        for (int i = 0; i < W * H; i++) begin
            step();
            check("s1_pixel",
                  {a_if.render_valid, a_if.render_x[7:0], a_if.render_y[7:0], a_if.render_index[7:0]},
                  {1'b1, 8'(i / H), 8'(i % H), 8'(i)});
        end
        step();
        check("s1_frame_done", a_fd, 1);
        check("s1_frame_count", a_fc, 1);
        check("s1_done_busy", a_busy, 1);
        check("s1_end_valid", a_if.render_valid, 0);
        check("s1_end_index", a_if.render_index, 0);
        step();
        check("s1_fd_pulse", a_fd, 0);
        check("s1_idle_busy", a_busy, 0);
        wait_a(SIG_FD, 100, n);
        check("s1_frame_period", n + 1, 40);
        check("s1_frame_count2", a_fc, 2);

        // Physics never answers: PHYS lasts STAGE_TIMEOUT cycles and timeout latches.
        rst_a = 1'b1; en_a = 1'b0; a_if.physics_done = 1'b0;
        repeat (2) step();
        rst_a = 1'b0; en_a = 1'b1;
        wait_a(SIG_PGO, 200, n);
        check("s2_go_latency", n, 40);
        check("s2_timeout_before", a_to, 0);
        wait_a(SIG_CGO, 20, n);
        check("s2_phys_length", n, 8);
        check("s2_timeout_set", a_to, 1);
        wait_a(SIG_FD, 50, n);
        check("s2_frame_done_delay", n, 14);
        step();
        check("s2_timeout_sticky", a_to, 1);
        a_if.physics_done = 1'b1;

        // collide_done only outside COLL: must be ignored, so COLL times out.
        rst_a = 1'b1; en_a = 1'b0; a_if.collide_done = 1'b0;
        repeat (2) step();
        rst_a = 1'b0; en_a = 1'b1;
        wait_a(SIG_PGO, 200, n);
        a_if.collide_done = 1'b1;
        step();
        check("s4_collide_go", a_if.collide_go, 1);
        check("s4_timeout_before", a_to, 0);
        a_if.collide_done = 1'b0;
        wait_a(SIG_VGO, 20, n);
        check("s4_coll_length", n, 8);
        check("s4_timeout_set", a_to, 1);
        a_if.collide_done = 1'b1;
        wait_a(SIG_FD, 30, n);
        check("s4_frame_done_delay", n, 13);
        check("s4_frame_count", a_fc, 1);

        // Reset while the scan is at index 5.
        wait_a(SIG_PGO, 100, n);
        repeat (8) step();
        check("s5_index_before", a_if.render_index, 5);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("s5_valid", a_if.render_valid, 0);
        check("s5_index", a_if.render_index, 0);
        check("s5_busy", a_busy, 0);
        check("s5_frame_count", a_fc, 0);
        check("s5_timeout", a_to, 0);
        wait_a(SIG_PGO, 200, n);
        check("s5_divider_restart", n, 40);

        // Enable dropped during VIEW: current frame finishes, nothing new starts.
        step();
        step();
        check("s6_in_view", a_if.view_go, 1);
        en_a = 1'b0;
        fd_cnt = 0; go_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (a_fd) fd_cnt++;
            if (a_if.physics_go) go_cnt++;
        end
        check("s6_frame_done_count", fd_cnt, 1);
        check("s6_no_physics_go", go_cnt, 0);
        check("s6_frame_count", a_fc, 1);
        en_a = 1'b1;
        wait_a(SIG_PGO, 200, n);
        check("s6_reenable_latency", n, 40);

        // Period 10 against a 17-cycle frame: every other tick is dropped.
        rst_b = 1'b0; en_b = 1'b1;
        fd_cnt = 0; go_cnt = 0; ovr_cnt = 0; first_ovr = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (b_fd) fd_cnt++;
            if (b_if.physics_go) go_cnt++;
            if (b_ovr) begin
                ovr_cnt++;
                if (first_ovr < 0) first_ovr = i;
            end
        end
        check("s3_physics_go_count", go_cnt, 10);
        check("s3_frame_done_count", fd_cnt, 9);
        check("s3_overrun_count", ovr_cnt, 10);
        check("s3_first_overrun", first_ovr, 20);
        check("s3_frame_count", b_fc, 9);
        check("s3_timeout", b_to, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
